// File: rtl/shreg_unload_ctrl.sv
// shreg_unload_ctrl: unloads one word from the Hamming-protected shift register by rotation, stalling on faults.
// Optional stall timeout: define SHREG_UNLOAD_STALL_TIMEOUT_EN to add err_timeout and abort after MAX_STALL consecutive stalls.
module shreg_unload_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CNT_W     = 8,
  parameter int MAX_STALL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  output logic             busy,
  output logic             reg_enable,
  output logic [1:0]       reg_mode,
  output logic             reg_load,
  output logic             reg_serial_in,
  input  logic             reg_serial_out,
  input  logic             reg_fault,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] fault_cnt
`ifdef SHREG_UNLOAD_STALL_TIMEOUT_EN
  , output logic           err_timeout
`endif
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic dir_q, dir_d, valid_q, valid_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, data_q, data_d, cap;
  logic [CNT_W-1:0] fc_q, fc_d;
`ifdef SHREG_UNLOAD_STALL_TIMEOUT_EN
  localparam int SW = $clog2(MAX_STALL + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic err_q, err_d;
  assign err_timeout = err_q;
`endif
  assign busy          = state_q != IDLE;
  assign reg_enable    = state_q == SHIFT && !reg_fault;
  assign reg_mode      = state_q == SHIFT ? {1'b0, dir_q} : 2'b11;
  assign reg_load      = 1'b0;
  assign reg_serial_in = reg_serial_out;
  assign word_data     = data_q;
  assign word_valid    = valid_q;
  assign fault_cnt     = fc_q;
  assign cap = dir_q ? {sh_q[WIDTH-2:0], reg_serial_out} : {reg_serial_out, sh_q[WIDTH-1:1]};
  // State and datapath registers; the asynchronous reset abandons any unload in progress.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fc_q    <= '0;
`ifdef SHREG_UNLOAD_STALL_TIMEOUT_EN
      stall_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fc_q    <= fc_d;
`ifdef SHREG_UNLOAD_STALL_TIMEOUT_EN
      stall_q <= stall_d;
      err_q   <= err_d;
`endif
    end
  // Next state: capture a bit only on fault-free SHIFT cycles so the HSR correction lands first.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    fc_d    = fc_q;
`ifdef SHREG_UNLOAD_STALL_TIMEOUT_EN
    stall_d = stall_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE:
        if (start) begin
          dir_d   = dir;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = SHIFT;
`ifdef SHREG_UNLOAD_STALL_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      SHIFT:
        if (reg_fault) begin
          fc_d = &fc_q ? fc_q : fc_q + 1'b1;
`ifdef SHREG_UNLOAD_STALL_TIMEOUT_EN
          stall_d = stall_q + 1'b1;
          if (stall_d == SW'(MAX_STALL)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
`endif
        end else begin
          sh_d  = cap;
          cnt_d = cnt_q + 1'b1;
`ifdef SHREG_UNLOAD_STALL_TIMEOUT_EN
          stall_d = '0;
`endif
          if (cnt_q == LAST) begin
            state_d = DONE;
            data_d  = cap;
            valid_d = 1'b1;
          end
        end
      DONE:
        if (word_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_shreg_unload_ctrl.sv
// tb_shreg_unload_ctrl: unloads words from a behavioural HSR with random fault injection and checks data, latency and stall counts.
module tb_shreg_unload_ctrl;
  localparam int W = 32;
  localparam int CW = 3;
  logic clk = 0, rst = 0, start = 0, dir = 0, word_ready = 0;
  logic busy, reg_enable, reg_load, reg_serial_in, reg_serial_out, reg_fault, word_valid;
  logic [1:0] reg_mode;
  logic [W-1:0] word_data;
  logic [CW-1:0] fault_cnt;
  logic [W-1:0] hsr = '0, flip = '0, cur, ld_val = '0, inj_mask = '0;
  logic ld_req = 0, inj_req = 0;
  int checks = 0, errors = 0, exp_fc = 0;

  shreg_unload_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .busy(busy),
    .reg_enable(reg_enable), .reg_mode(reg_mode), .reg_load(reg_load),
    .reg_serial_in(reg_serial_in), .reg_serial_out(reg_serial_out), .reg_fault(reg_fault),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural HSR: flip holds a pending single-bit upset; any non-shifting edge corrects it.
  assign cur = hsr ^ flip;
  assign reg_serial_out = reg_mode[0] ? cur[W-1] : cur[0];
  assign reg_fault = |flip;
  always @(posedge clk) begin
    if (ld_req) hsr <= ld_val;
    else if (reg_enable && reg_mode == 2'b00) hsr <= {reg_serial_in, cur[W-1:1]};
    else if (reg_enable && reg_mode == 2'b01) hsr <= {cur[W-2:0], reg_serial_in};
    flip <= inj_req ? inj_mask : '0;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] w);
    @(negedge clk);
    ld_val = w;
    ld_req = 1;
    @(negedge clk);
    ld_req = 0;
  endtask

  task automatic run_word(input logic [W-1:0] w, input logic d, input int pct);
    int cyc, stalls;
    load(w);
    start = 1;
    dir = d;
    word_ready = 1'($urandom % 2);
    @(negedge clk);
    start = 0;
    word_ready = 0;
    dir = ~d;
    chk("busy_after_start", {31'b0, busy}, 1);
    cyc = 0;
    stalls = 0;
    while (!word_valid && cyc < 3 * W) begin
      chk("shift_mode", {30'b0, reg_mode}, {31'b0, d});
      if (reg_fault) stalls++;
      inj_mask = d ? 32'h8000_0000 : 32'h1;
      inj_req = !reg_fault && ($urandom_range(99) < pct);
      @(negedge clk);
      cyc++;
    end
    inj_req = 0;
    exp_fc = (exp_fc + stalls > 7) ? 7 : exp_fc + stalls;
    chk("latency", cyc, W + stalls);
    chk("word_data", word_data, w);
    chk("hsr_restored", hsr, w);
    chk("fault_cnt", {29'b0, fault_cnt}, exp_fc);
    repeat ($urandom_range(1, 10)) begin
      start = 1'($urandom % 2);
      @(negedge clk);
      chk("done_valid", {31'b0, word_valid}, 1);
      chk("done_data", word_data, w);
      chk("done_enable_mode", {29'b0, reg_enable, reg_mode}, 3);
      chk("done_fault_cnt", {29'b0, fault_cnt}, exp_fc);
    end
    start = 0;
    word_ready = 1;
    @(negedge clk);
    word_ready = 0;
    chk("accept_idle", {30'b0, busy, word_valid}, 0);
  endtask

  initial begin
    int caps;
    #1;
    chk("rst_busy_valid", {30'b0, busy, word_valid}, 0);
    chk("rst_data", word_data, 0);
    chk("rst_fault_cnt", {29'b0, fault_cnt}, 0);
    chk("rst_outputs", {28'b0, reg_enable, reg_load, reg_mode}, 3);
    @(negedge clk);
    rst = 1;
    run_word(32'hA5C3_0F96, 0, 0);
    run_word(32'hA5C3_0F96, 1, 0);
    // A fault while idle is corrected by the HSR and must not be counted.
    @(negedge clk);
    inj_mask = 32'h1;
    inj_req = 1;
    @(negedge clk);
    inj_req = 0;
    chk("idle_fault_seen", {31'b0, reg_fault}, 1);
    @(negedge clk);
    chk("idle_fault_uncounted", {29'b0, fault_cnt}, exp_fc);
    for (int i = 0; i < 12; i++) run_word($urandom, 1'($urandom % 2), 8);
    // Reset in the middle of a shift.
    load($urandom);
    start = 1;
    dir = 0;
    @(negedge clk);
    start = 0;
    caps = 0;
    while (caps < 12) begin
      if (reg_enable) caps++;
      @(negedge clk);
    end
    rst = 0;
    #1;
    chk("midrst_busy_valid", {30'b0, busy, word_valid}, 0);
    chk("midrst_fault_cnt", {29'b0, fault_cnt}, 0);
    chk("midrst_enable", {31'b0, reg_enable}, 0);
    exp_fc = 0;
    @(negedge clk);
    rst = 1;
    run_word($urandom, 1'($urandom % 2), 10);
    run_word($urandom, 1'($urandom % 2), 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
